keypad_entry_buffer: RTL and testbench

// Consumes the 16-bit one-cycle key_edge vector from the keypad input stage and assembles a

---
 rtl/keypad_entry_buffer_if.sv | 26 ++
 rtl/keypad_entry_buffer.sv | 139 +++++++++++++
 tb/tb_keypad_entry_buffer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_buffer_if.sv
// Handshake bundle between the keypad input stage, the entry buffer and the code consumer.
// The master side drives key edges and the acknowledge; the slave side owns the code outputs.
interface keypad_entry_buffer_if #(
  parameter int MAX_DIGITS = 4,
  parameter int CNT_W      = 3
);
  logic [15:0]             key_edge;
  logic                    code_ack;
  logic [4*MAX_DIGITS-1:0] digits;
  logic [CNT_W-1:0]        digit_count;
  logic                    entry_active;
  logic                    code_valid;
  logic                    overflow;
  logic                    multi_key;
  logic                    timeout;

  modport master (
    output key_edge, code_ack,
    input  digits, digit_count, entry_active, code_valid, overflow, multi_key, timeout
  );

  modport slave (
    input  key_edge, code_ack,
    output digits, digit_count, entry_active, code_valid, overflow, multi_key, timeout
  );
endinterface

// File: rtl/keypad_entry_buffer.sv
// Assembles keypad digit presses into a BCD code with backspace, clear, enter and an
// inactivity timeout, then holds the code until the consumer acknowledges it.
module keypad_entry_buffer #(
  parameter int MAX_DIGITS     = 4,
  parameter int CNT_W          = 3,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  keypad_entry_buffer_if.slave  kb
);

  localparam int DW    = 4 * MAX_DIGITS;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(MAX_DIGITS);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    DONE
  } state_t;

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;

  logic       key_any;
  logic       key_valid;
  logic       key_multi;
  logic       key_digit;
  logic [3:0] key_idx;

  // One-hot test: exactly one bit set means x & (x-1) clears it to zero.
  always_comb begin
    key_any   = |kb.key_edge;
    key_valid = key_any && ((kb.key_edge & (kb.key_edge - 16'd1)) == 16'd0);
    key_multi = key_any && !key_valid;
    key_idx   = 4'd0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (kb.key_edge[i]) key_idx = i[3:0];
    end
    key_digit = key_valid && (key_idx <= 4'd9);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      tmo_cnt         <= '0;
      kb.digits       <= '0;
      kb.digit_count  <= '0;
      kb.entry_active <= 1'b0;
      kb.code_valid   <= 1'b0;
      kb.overflow     <= 1'b0;
      kb.multi_key    <= 1'b0;
      kb.timeout      <= 1'b0;
    end else begin
      kb.overflow  <= 1'b0;
      kb.multi_key <= 1'b0;
      kb.timeout   <= 1'b0;

      unique case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (key_multi) begin
            kb.multi_key <= 1'b1;
          end else if (key_digit) begin
            state           <= ENTRY;
            kb.entry_active <= 1'b1;
            kb.digits       <= DW'(key_idx);
            kb.digit_count  <= CNT_W'(1);
          end
        end

        ENTRY: begin
          if (key_valid) begin
            tmo_cnt <= '0;
            if (key_digit) begin
              if (kb.digit_count == FULL_CNT) begin
                kb.overflow <= 1'b1;
              end else begin
                kb.digits      <= (kb.digits << 4) | DW'(key_idx);
                kb.digit_count <= kb.digit_count + CNT_W'(1);
              end
            end else if (key_idx == 4'd10) begin
              state           <= DONE;
              kb.entry_active <= 1'b0;
              kb.code_valid   <= 1'b1;
            end else if (key_idx == 4'd11) begin
              kb.digits      <= kb.digits >> 4;
              kb.digit_count <= kb.digit_count - CNT_W'(1);
              if (kb.digit_count == CNT_W'(1)) begin
                state           <= IDLE;
                kb.entry_active <= 1'b0;
              end
            end else if (key_idx == 4'd12) begin
              state           <= IDLE;
              kb.entry_active <= 1'b0;
              kb.digits       <= '0;
              kb.digit_count  <= '0;
            end
          end else begin
            // A multi-key cycle is not a valid key, so it neither clears nor blocks the timer.
            kb.multi_key <= key_multi;
            if (tmo_cnt == TMO_LIMIT) begin
              state           <= IDLE;
              tmo_cnt         <= '0;
              kb.entry_active <= 1'b0;
              kb.digits       <= '0;
              kb.digit_count  <= '0;
              kb.timeout      <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
        end

        DONE: begin
          tmo_cnt <= '0;
          if (kb.code_ack || (key_valid && key_idx == 4'd12)) begin
            state          <= IDLE;
            kb.code_valid  <= 1'b0;
            kb.digits      <= '0;
            kb.digit_count <= '0;
          end
        end

        default: begin
          state           <= IDLE;
          tmo_cnt         <= '0;
          kb.entry_active <= 1'b0;
          kb.code_valid   <= 1'b0;
          kb.digits       <= '0;
          kb.digit_count  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Directed bench for keypad_entry_buffer with a short inactivity limit so timeouts are reachable.
module tb_keypad_entry_buffer;

  localparam int MAX_DIGITS = 4;
  localparam int CNT_W      = 3;
  localparam int TMO        = 20;

  localparam logic [15:0] K_ENTER = 16'h0400;
  localparam logic [15:0] K_BS    = 16'h0800;
  localparam logic [15:0] K_CLEAR = 16'h1000;
  localparam logic [15:0] K_13    = 16'h2000;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  keypad_entry_buffer_if #(.MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) kb ();

  keypad_entry_buffer #(
    .MAX_DIGITS     (MAX_DIGITS),
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kb  (kb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] kbit(input int d);
    logic [15:0] one;
    one = 16'h0001;
    return one << d;
  endfunction

  // Present one cycle of key/ack input, then sample just after the capturing edge.
  task automatic step(input logic [15:0] k, input logic ack);
    @(negedge clk);
    kb.key_edge = k;
    kb.code_ack = ack;
    @(posedge clk);
    #1;
    kb.key_edge = '0;
    kb.code_ack = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [15:0] d, input logic [2:0] c,
                           input logic act, input logic vld);
    check({tag, ".digits"}, 32'(kb.digits), 32'(d));
    check({tag, ".count"},  32'(kb.digit_count), 32'(c));
    check({tag, ".active"}, 32'(kb.entry_active), 32'(act));
    check({tag, ".valid"},  32'(kb.code_valid), 32'(vld));
  endtask

  task automatic chk_pulses(input string tag, input logic ov, input logic mk, input logic to);
    check({tag, ".overflow"},  32'(kb.overflow), 32'(ov));
    check({tag, ".multi_key"}, 32'(kb.multi_key), 32'(mk));
    check({tag, ".timeout"},   32'(kb.timeout), 32'(to));
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b0;
    kb.key_edge = '0;
    kb.code_ack = 1'b0;

    // Reset state
    #12;
    chk_state("reset", 16'h0000, 3'd0, 1'b0, 1'b0);
    chk_pulses("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // 1: enter 1234 and hand it off
    step(kbit(1), 1'b0);
    chk_state("t1.first", 16'h0001, 3'd1, 1'b1, 1'b0);
    step(kbit(2), 1'b0);
    step(kbit(3), 1'b0);
    step(kbit(4), 1'b0);
    chk_state("t1.full", 16'h1234, 3'd4, 1'b1, 1'b0);
    step(K_ENTER, 1'b0);
    chk_state("t1.done", 16'h1234, 3'd4, 1'b0, 1'b1);
    step(kbit(7), 1'b0);
    chk_state("t1.done_digit", 16'h1234, 3'd4, 1'b0, 1'b1);
    step(16'h0003, 1'b0);
    chk_pulses("t1.done_multi", 1'b0, 1'b0, 1'b0);
    step(16'h0000, 1'b1);
    chk_state("t1.ack", 16'h0000, 3'd0, 1'b0, 1'b0);
    chk_pulses("t1.ack", 1'b0, 1'b0, 1'b0);

    // 2: fifth digit overflows
    step(kbit(5), 1'b0);
    step(kbit(6), 1'b0);
    step(kbit(7), 1'b0);
    step(kbit(8), 1'b0);
    step(kbit(9), 1'b0);
    chk_state("t2.ovf", 16'h5678, 3'd4, 1'b1, 1'b0);
    chk_pulses("t2.ovf", 1'b1, 1'b0, 1'b0);
    step(16'h0000, 1'b0);
    chk_pulses("t2.after", 1'b0, 1'b0, 1'b0);
    step(K_CLEAR, 1'b0);
    chk_state("t2.clear", 16'h0000, 3'd0, 1'b0, 1'b0);

    // 3: backspace down to empty
    step(kbit(7), 1'b0);
    step(kbit(8), 1'b0);
    chk_state("t3.two", 16'h0078, 3'd2, 1'b1, 1'b0);
    step(K_BS, 1'b0);
    chk_state("t3.bs1", 16'h0007, 3'd1, 1'b1, 1'b0);
    step(K_BS, 1'b0);
    chk_state("t3.bs2", 16'h0000, 3'd0, 1'b0, 1'b0);

    // 4: multi-key in ENTRY
    step(kbit(2), 1'b0);
    step(16'h0003, 1'b0);
    chk_state("t4.multi", 16'h0002, 3'd1, 1'b1, 1'b0);
    chk_pulses("t4.multi", 1'b0, 1'b1, 1'b0);
    step(16'h0000, 1'b0);
    chk_pulses("t4.after", 1'b0, 1'b0, 1'b0);
    step(K_CLEAR, 1'b0);

    // 5a: inactivity timeout after 20 idle cycles
    step(kbit(4), 1'b0);
    for (int i = 0; i < TMO - 1; i++) step(16'h0000, 1'b0);
    chk_state("t5.pre", 16'h0004, 3'd1, 1'b1, 1'b0);
    chk_pulses("t5.pre", 1'b0, 1'b0, 1'b0);
    step(16'h0000, 1'b0);
    chk_state("t5.tmo", 16'h0000, 3'd0, 1'b0, 1'b0);
    chk_pulses("t5.tmo", 1'b0, 1'b0, 1'b1);
    step(16'h0000, 1'b0);
    chk_pulses("t5.tmo_end", 1'b0, 1'b0, 1'b0);

    // 5b: a press on the 19th cycle restarts the timer
    step(kbit(4), 1'b0);
    for (int i = 0; i < TMO - 2; i++) step(16'h0000, 1'b0);
    step(kbit(5), 1'b0);
    chk_state("t5.late", 16'h0045, 3'd2, 1'b1, 1'b0);
    chk_pulses("t5.late", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TMO - 1; i++) step(16'h0000, 1'b0);
    chk_state("t5.restart", 16'h0045, 3'd2, 1'b1, 1'b0);
    check("t5.restart.timeout", 32'(kb.timeout), 32'd0);
    step(K_CLEAR, 1'b0);

    // 6a: control keys and ack in IDLE do nothing
    step(K_ENTER, 1'b0);
    step(K_BS, 1'b0);
    step(K_CLEAR, 1'b0);
    step(K_13, 1'b0);
    step(16'h0000, 1'b1);
    chk_state("t6.idle", 16'h0000, 3'd0, 1'b0, 1'b0);

    // 6b: asynchronous reset mid-entry
    step(kbit(3), 1'b0);
    step(kbit(9), 1'b0);
    chk_state("t6.pre_rst", 16'h0039, 3'd2, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_state("t6.async_rst", 16'h0000, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // 6c: CLEAR together with ack in DONE gives one exit
    step(kbit(1), 1'b0);
    step(K_ENTER, 1'b0);
    chk_state("t6.done", 16'h0001, 3'd1, 1'b0, 1'b1);
    step(K_CLEAR, 1'b1);
    chk_state("t6.exit", 16'h0000, 3'd0, 1'b0, 1'b0);
    step(16'h0000, 1'b0);
    chk_state("t6.stay", 16'h0000, 3'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
